// File: rtl/ss_display.sv
`default_nettype none
// ============================================================================
// Module      : ss_display
// Description : Captures a signed 8-bit product, converts its magnitude to
//               BCD with a shift-add-3 sequencer and scans it onto a 4-digit
//               active-low seven-segment display with sign and leading-zero
//               blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module ss_display #(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       done,
   input  logic [7:0] result,
   output logic       busy,
   output logic [6:0] seg,
   output logic [3:0] an
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_SHOW = 2'd2;

   localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   // Internal digit codes: 0..9 are decimal digits, plus dash and blank.
   localparam logic [3:0] CODE_DASH  = 4'd10;
   localparam logic [3:0] CODE_BLANK = 4'd15;

   logic [1:0]       state_q, state_d;
   logic             sign_q;
   logic [7:0]       mag_q;
   logic [11:0]      bcd_q;
   logic [2:0]       iter_q;
   logic [3:0]       disp_h_q, disp_t_q, disp_o_q;
   logic             disp_sign_q;
   logic [CNT_W-1:0] refresh_q;
   logic [1:0]       digit_q;

   logic [11:0]      bcd_adj_d;
   logic [11:0]      bcd_next_d;
   logic [3:0]       code_d;

   // Add 3 to every BCD nibble that is 5 or more before the next shift.
   always_comb begin
      bcd_adj_d = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) begin
            bcd_adj_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
         end
      end
   end

   assign bcd_next_d = {bcd_adj_d[10:0], mag_q[7]};

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; done is only honoured outside a conversion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_SHOW: if (done) state_d = S_CONV;
         S_CONV:         if (iter_q == 3'd7) state_d = S_SHOW;
         default:        state_d = S_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state_q == S_CONV);
   end

   // Conversion datapath: capture, eight shift steps, atomic display update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sign_q      <= 1'b0;
         mag_q       <= 8'd0;
         bcd_q       <= 12'd0;
         iter_q      <= 3'd0;
         disp_h_q    <= 4'd0;
         disp_t_q    <= 4'd0;
         disp_o_q    <= 4'd0;
         disp_sign_q <= 1'b0;
      end else begin
         case (state_q)
            S_CONV: begin
               {bcd_q, mag_q} <= {bcd_adj_d[10:0], mag_q, 1'b0};
               iter_q         <= iter_q + 3'd1;
               if (iter_q == 3'd7) begin
                  disp_h_q    <= bcd_next_d[11:8];
                  disp_t_q    <= bcd_next_d[7:4];
                  disp_o_q    <= bcd_next_d[3:0];
                  disp_sign_q <= sign_q;
               end
            end
            default: begin
               if (done) begin
                  // Two's-complement negate; 8'h80 maps to 128 unsigned.
                  sign_q <= result[7];
                  mag_q  <= result[7] ? (~result + 8'd1) : result;
                  bcd_q  <= 12'd0;
                  iter_q <= 3'd0;
               end
            end
         endcase
      end
   end

   // Free-running scan: hold each digit for REFRESH_DIV cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         refresh_q <= '0;
         digit_q   <= 2'd0;
      end else if (refresh_q == CNT_MAX) begin
         refresh_q <= '0;
         digit_q   <= digit_q + 2'd1;
      end else begin
         refresh_q <= refresh_q + 1'b1;
      end
   end

   // Select the code of the scanned digit with sign and leading-zero blanking.
   always_comb begin
      code_d = CODE_BLANK;
      case (digit_q)
         2'd0: code_d = disp_o_q;
         2'd1: code_d = (disp_h_q == 4'd0 && disp_t_q == 4'd0) ? CODE_BLANK : disp_t_q;
         2'd2: code_d = (disp_h_q == 4'd0) ? CODE_BLANK : disp_h_q;
         2'd3: code_d = disp_sign_q ? CODE_DASH : CODE_BLANK;
         default: code_d = CODE_BLANK;
      endcase
   end

   // Active-low segment decoder, {g,f,e,d,c,b,a}.
   always_comb begin
      seg = 7'b1111111;
      case (code_d)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         4'd10:   seg = 7'b0111111;
         default: seg = 7'b1111111;
      endcase
   end

   assign an = ~(4'b0001 << digit_q);

endmodule
`default_nettype wire

// File: tb/tb_ss_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_ss_display
// Description : Directed self-checking bench for ss_display (REFRESH_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ss_display;

   localparam int DIV = 4;
   localparam int B   = 15;   // blank
   localparam int D   = 10;   // dash

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       done = 1'b0;
   logic [7:0] result = 8'd0;
   logic       busy;
   logic [6:0] seg;
   logic [3:0] an;

   int checks = 0;
   int errors = 0;
   int prev[4];

   ss_display #(.REFRESH_DIV(DIV)) dut (
      .clk    (clk),
      .rst    (rst),
      .done   (done),
      .result (result),
      .busy   (busy),
      .seg    (seg),
      .an     (an)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int code);
      case (code)
         0:  return 7'b1000000;
         1:  return 7'b1111001;
         2:  return 7'b0100100;
         3:  return 7'b0110000;
         4:  return 7'b0011001;
         5:  return 7'b0010010;
         6:  return 7'b0000010;
         7:  return 7'b1111000;
         8:  return 7'b0000000;
         9:  return 7'b0010000;
         10: return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) until digit idx is scanned, then check its pattern.
   task automatic chk_digit(input string tag, input int idx, input int code);
      logic [3:0] want_an;
      bit         seen;
      want_an = ~(4'b0001 << idx);
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (an === want_an) seen = 1'b1;
      end
      if (!seen) chk({tag, " scan timeout"}, 32'(an), 32'(want_an));
      else       chk(tag, 32'(seg), 32'(seg_of(code)));
   endtask

   task automatic chk_display(input string tag, input int d3, input int d2, input int d1, input int d0);
      chk_digit({tag, " d3"}, 3, d3);
      chk_digit({tag, " d2"}, 2, d2);
      chk_digit({tag, " d1"}, 1, d1);
      chk_digit({tag, " d0"}, 0, d0);
      prev[3] = d3; prev[2] = d2; prev[1] = d1; prev[0] = d0;
   endtask

   // Drive a one-cycle done pulse; returns at the negedge after edge k.
   task automatic pulse(input logic [7:0] val);
      @(negedge clk);
      done   = 1'b1;
      result = val;
      @(negedge clk);
      done   = 1'b0;
   endtask

   // Count cycles busy stays high, starting right after edge k.
   task automatic chk_busy_len(input string tag);
      int cnt;
      cnt = 0;
      while (busy === 1'b1 && cnt < 20) begin
         cnt++;
         @(negedge clk);
      end
      chk(tag, 32'(cnt), 32'd8);
   endtask

   // Convert and check: busy length, then all four digits.
   task automatic convert(input string tag, input logic [7:0] val,
                          input int d3, input int d2, input int d1, input int d0);
      pulse(val);
      chk_busy_len({tag, " busy"});
      chk_display(tag, d3, d2, d1, d0);
   endtask

   initial begin
      int idx;
      int cnt;
      // Reset state while held.
      repeat (3) @(negedge clk);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst an", 32'(an), 32'b1110);
      chk("rst seg", 32'(seg), 32'(7'b1000000));

      // Release on a negedge and watch the scan sequence.
      rst = 1'b1;
      for (int n = 0; n <= 16; n++) begin
         if (n > 0) @(negedge clk);
         chk($sformatf("scan %0d", n), 32'(an), 32'(~(4'b0001 << ((n / DIV) % 4)) & 4'hF));
      end
      chk_display("post-rst", B, B, B, 0);

      convert("r6", 8'd6, B, B, B, 6);

      // -12 with a mid-conversion hold check of the previous value.
      pulse(8'hF4);
      repeat (4) @(negedge clk);
      idx = 0;
      for (int i = 0; i < 4; i++) if (an[i] == 1'b0) idx = i;
      chk("hold mid-conv", 32'(seg), 32'(seg_of(prev[idx])));
      chk("hold busy", 32'(busy), 32'd1);
      repeat (10) @(negedge clk);
      chk_display("rF4", D, B, 1, 2);

      convert("r31", 8'h31, B, B, 4, 9);
      convert("r80", 8'h80, D, 1, 2, 8);
      convert("r00", 8'h00, B, B, B, 0);

      // done during CONV is ignored.
      @(negedge clk);
      done = 1'b1; result = 8'd9;
      cnt = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (n == 0) done = 1'b0;
         if (n == 2) begin done = 1'b1; result = 8'd5; end
         if (n == 3) done = 1'b0;
         if (busy === 1'b1) cnt++;
      end
      chk("ignore busy len", 32'(cnt), 32'd8);
      chk_display("ignore", B, B, B, 9);

      // Asynchronous reset mid-conversion of -12.
      pulse(8'hF4);
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort an", 32'(an), 32'b1110);
      chk("abort seg", 32'(seg), 32'(7'b1000000));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort no busy", 32'(busy), 32'd0);
      chk_display("abort", B, B, B, 0);

      convert("fresh", 8'd3, B, B, B, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
